// File: rtl/profibus_rx_sampler_if.sv
// rtl/profibus_rx_sampler_if.sv - byte handoff bus between the PROFIBUS receive sampler and the telegram layer
//
// Signals:
//   rx_data    [7:0]  received byte, meaningful while rx_valid = 1
//   rx_valid          byte available, held until acknowledged
//   rx_ack            consumer acknowledge, one-cycle pulse
//   parity_err        even-parity mismatch for the byte in rx_data
//   frame_err         stop bit sampled as 0 for the byte in rx_data
//   overrun           sticky: a completed byte was dropped
//
// Modports:
//   master  - the sampler (drives the byte and status, takes rx_ack)
//   slave   - the consumer (reads the byte and status, drives rx_ack)

interface profibus_rx_sampler_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output overrun,
        input  rx_ack
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  overrun,
        output rx_ack
    );

endinterface

// File: rtl/profibus_rx_sampler.sv
// rtl/profibus_rx_sampler.sv - PROFIBUS character receiver: sync, start-bit hunt, 11-bit UART sampling, byte handoff
//
// Receives one character of start, 8 data bits (LSB first), even parity
// and stop, then presents the byte on a valid/ack handshake.
//
// Parameters:
//   CLK_HZ  system clock frequency in Hz
//   BAUD    line bit rate; CLKS_PER_BIT = CLK_HZ / BAUD, must be >= 4
//
// Ports:
//   clk    input   system clock, rising edge
//   rst    input   synchronous active-high reset
//   rx     input   raw asynchronous receive line, idle high
//   busy   output  bit-timing state machine is not idle
//   rx_if  master  byte handoff bus (rx_data, rx_valid, rx_ack,
//                  parity_err, frame_err, overrun)
//
// Build option:
//   RX_MAJORITY_VOTE_EN  each bit is decided by a 2-of-3 vote over the
//                        synchronized line at center-1, center, center+1;
//                        the decision lands on center+1, so every sample
//                        point moves one cycle later. Without it a single
//                        sample is taken at the center cycle.

module profibus_rx_sampler #(
    parameter int CLK_HZ = 24000000,
    parameter int BAUD   = 19200
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx,
    output logic                        busy,
    profibus_rx_sampler_if.master       rx_if
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;

`ifdef RX_MAJORITY_VOTE_EN
    localparam int VOTE_DELAY = 1;
`else
    localparam int VOTE_DELAY = 0;
`endif

    // START counts from 0 on the cycle after the edge, so the start-bit
    // decision falls HALF_BIT + 1 cycles after the edge-detect cycle.
    // HALF_BIT + 1 <= CLKS_PER_BIT - 1 whenever CLKS_PER_BIT >= 4, so the
    // terminal value always fits in the cycle counter.
    localparam logic [CW-1:0] START_LAST = CW'(HALF_BIT + VOTE_DELAY);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Line synchronizer and edge detector history
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          prev_q,  prev_d;

    // Bit timing
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q,   par_d;

    // Handoff registers
    logic [7:0]    data_q,  data_d;
    logic          valid_q, valid_d;
    logic          perr_q,  perr_d;
    logic          ferr_q,  ferr_d;
    logic          ovr_q,   ovr_d;

    logic          fall;
    logic          sample_pt;
    logic          sample_bit;

    // prev_q doubles as the one-cycle-old synchronized line for the vote.
    assign fall = prev_q & ~sync2_q;

`ifdef RX_MAJORITY_VOTE_EN
    logic prev2_q, prev2_d;

    // Votes over sync2 at center+1, prev at center, prev2 at center-1.
    assign sample_bit = (sync2_q & prev_q) | (sync2_q & prev2_q) | (prev_q & prev2_q);

    always_comb begin
        prev2_d = prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev2_q <= 1'b1;
        end else begin
            prev2_q <= prev2_d;
        end
    end
`else
    assign sample_bit = sync2_q;
`endif

    assign sample_pt = (state_q == ST_START) ? (cnt_q == START_LAST)
                                             : (cnt_q == BIT_LAST);

    always_comb begin
        sync1_d   = rx;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;

        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;

        data_d    = data_q;
        valid_d   = valid_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        ovr_d     = ovr_q;

        // Consumer acknowledge frees the holding register; a commit in
        // the same cycle below overrides the clear.
        if (rx_if.rx_ack && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end

        // Cycle counter free-runs inside a character and restarts at
        // every sample point so the period is exactly CLKS_PER_BIT.
        if (state_q != ST_IDLE) begin
            cnt_d = sample_pt ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                if (fall) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (sample_pt) begin
                    // High at mid start bit is a glitch: drop silently.
                    state_d = sample_bit ? ST_IDLE : ST_DATA;
                end
            end

            ST_DATA: begin
                if (sample_pt) begin
                    shreg_d   = {sample_bit, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end

            ST_PARITY: begin
                if (sample_pt) begin
                    par_d   = sample_bit;
                    state_d = ST_STOP;
                end
            end

            ST_STOP: begin
                if (sample_pt) begin
                    state_d = ST_IDLE;
                    // Free slot, or the consumer is emptying it this very
                    // cycle: load. Otherwise the new byte is lost.
                    if (!valid_q || rx_if.rx_ack) begin
                        data_d  = shreg_q;
                        perr_d  = ^shreg_q ^ par_q;
                        ferr_d  = ~sample_bit;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Line idles high, so the synchronizer resets high to avoid
            // a phantom falling edge when reset releases.
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign busy             = (state_q != ST_IDLE);
    assign rx_if.rx_data    = data_q;
    assign rx_if.rx_valid   = valid_q;
    assign rx_if.parity_err = perr_q;
    assign rx_if.frame_err  = ferr_q;
    assign rx_if.overrun    = ovr_q;

endmodule

// File: tb/tb_profibus_rx_sampler.sv
// tb/tb_profibus_rx_sampler.sv - scoreboard bench for profibus_rx_sampler
`timescale 1ns/1ps

module tb_profibus_rx_sampler;

    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 100000;
    localparam int CPB    = CLK_HZ / BAUD;

`ifdef RX_MAJORITY_VOTE_EN
    localparam int VOTE_DLY = 1;
`else
    localparam int VOTE_DLY = 0;
`endif

    // Edges counted from the first edge that samples the start bit:
    // detector fires after edge 1, start sample CPB/2+1 later, ten more
    // bit periods to the stop sample, one cycle to register the commit.
    localparam int LAT       = 1 + (CPB / 2 + 1) + 10 * CPB + 1 + VOTE_DLY;
    localparam int GLITCH_BUSY = CPB / 2 + 1 + VOTE_DLY;

    logic clk = 1'b0;
    logic rst;
    logic rx;
    logic busy;

    profibus_rx_sampler_if bus ();

    profibus_rx_sampler #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rx    (rx),
        .busy  (busy),
        .rx_if (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: a character is delivered with its data byte, a parity
    // error when the count of ones over data+parity is odd, and a frame
    // error when the stop bit is low.
    function automatic exp_t model(input logic [7:0] b, input logic par, input logic stop);
        exp_t e;
        e.data = b;
        e.perr = ($countones({b, par}) % 2) == 1;
        e.ferr = (stop == 1'b0);
        return e;
    endfunction

    // Drives one character from the current negedge, one bit per CPB
    // cycles; spike_bit/spike_off invert a single cycle inside one bit.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                              input int spike_bit, input int spike_off);
        logic [10:0] line;
        line = {stop, par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            for (int j = 0; j < CPB; j++) begin
                rx = line[i] ^ ((i == spike_bit) && (j == spike_off));
                @(negedge clk);
            end
        end
        rx = 1'b1;
    endtask

    task automatic send_expect(input logic [7:0] b, input logic par, input logic stop);
        exp_q.push_back(model(b, par, stop));
        send_frame(b, par, stop, -1, 0);
    endtask

    task automatic wait_valid(input string name);
        for (int k = 0; k < 400; k++) begin
            if (bus.rx_valid === 1'b1) return;
            @(posedge clk);
            #2;
        end
        check({name, " valid timeout"}, 0, 1);
    endtask

    task automatic ack_pulse(input string name);
        @(negedge clk);
        bus.rx_ack = 1'b1;
        @(posedge clk);
        #2;
        check({name, " ack clears valid"}, bus.rx_valid, 0);
        check({name, " ack clears overrun"}, bus.overrun, 0);
        @(negedge clk);
        bus.rx_ack = 1'b0;
    endtask

    // Monitor: a delivery is rx_valid rising, or rx_valid staying high
    // across an edge that carried rx_ack (new byte loaded on ack).
    initial begin
        logic vprev;
        exp_t e;
        vprev = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.rx_valid === 1'b1 && (vprev !== 1'b1 || bus.rx_ack === 1'b1)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected delivery", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", bus.rx_data, e.data);
                    check("parity_err", bus.parity_err, e.perr);
                    check("frame_err", bus.frame_err, e.ferr);
                end
            end
            vprev = bus.rx_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bcnt;
        logic [7:0] b;
        logic pbad, sbad;

        rst = 1'b1;
        rx = 1'b1;
        bus.rx_ack = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset busy", busy, 0);
        check("reset rx_valid", bus.rx_valid, 0);
        check("reset rx_data", bus.rx_data, 0);
        check("reset parity_err", bus.parity_err, 0);
        check("reset frame_err", bus.frame_err, 0);
        check("reset overrun", bus.overrun, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 0xA5, good parity and stop, latency from start bit
        lat = -1;
        exp_q.push_back(model(8'hA5, 1'b0, 1'b1));
        fork
            send_frame(8'hA5, 1'b0, 1'b1, -1, 0);
            begin
                for (int k = 0; k < 300; k++) begin
                    @(posedge clk);
                    #2;
                    if (bus.rx_valid === 1'b1) begin
                        lat = k;
                        break;
                    end
                end
            end
        join
        check("A5 latency", lat, LAT);
        ack_pulse("A5");

        // Parity error and framing error
        repeat (3) @(negedge clk);
        send_expect(8'h01, 1'b0, 1'b1);
        wait_valid("01");
        ack_pulse("01");
        repeat (3) @(negedge clk);
        send_expect(8'h3C, 1'b0, 1'b0);
        wait_valid("3C");
        ack_pulse("3C");

        // One-cycle glitch is a false start
        repeat (5) @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        bcnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #2;
            if (busy === 1'b1) bcnt++;
        end
        check("glitch busy cycles", bcnt, GLITCH_BUSY);
        check("glitch no valid", bus.rx_valid, 0);

        // Overrun: second byte dropped
        @(negedge clk);
        send_expect(8'h11, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        send_frame(8'h22, 1'b0, 1'b1, -1, 0);
        repeat (3) @(negedge clk);
        check("overrun set", bus.overrun, 1);
        check("overrun keeps old byte", bus.rx_data, 8'h11);
        check("overrun keeps valid", bus.rx_valid, 1);
        ack_pulse("overrun");

        // Ack on the commit cycle of a second byte
        repeat (3) @(negedge clk);
        send_expect(8'h33, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        exp_q.push_back(model(8'h55, 1'b0, 1'b1));
        fork
            send_frame(8'h55, 1'b0, 1'b1, -1, 0);
            begin
                repeat (LAT) @(negedge clk);
                bus.rx_ack = 1'b1;
                @(negedge clk);
                bus.rx_ack = 1'b0;
            end
        join
        check("ack-on-commit valid", bus.rx_valid, 1);
        check("ack-on-commit data", bus.rx_data, 8'h55);
        check("ack-on-commit overrun", bus.overrun, 0);

        // Reset in the middle of 0xFF data bits
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("midrst busy", busy, 0);
        check("midrst rx_valid", bus.rx_valid, 0);
        check("midrst rx_data", bus.rx_data, 0);
        check("midrst parity_err", bus.parity_err, 0);
        check("midrst frame_err", bus.frame_err, 0);
        check("midrst overrun", bus.overrun, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (7 * CPB) @(negedge clk);
        send_expect(8'h0F, 1'b0, 1'b1);
        wait_valid("0F");
        ack_pulse("0F");

`ifdef RX_MAJORITY_VOTE_EN
        // Spike at the center of data bit 3 (line bit 4) is voted out
        repeat (3) @(negedge clk);
        exp_q.push_back(model(8'h00, 1'b0, 1'b1));
        send_frame(8'h00, 1'b0, 1'b1, 4, CPB / 2 + 1);
        wait_valid("spike");
        ack_pulse("spike");
`endif

        // Randomized characters
        for (int n = 0; n < 12; n++) begin
            repeat ($urandom_range(1, 15)) @(negedge clk);
            b    = 8'($urandom);
            pbad = ($urandom_range(0, 3) == 0);
            sbad = ($urandom_range(0, 3) == 0);
            send_expect(b, (^b) ^ pbad, ~sbad);
            wait_valid("random");
            ack_pulse("random");
        end

        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        check("scoreboard drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
